// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel edge/center-aligned PWM with shadowed settings
// applied at period boundaries.
module pwm_multi #(
    parameter int PWM_CNT  = 10,
    parameter int CHANNELS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         mode,
    input  logic [PWM_CNT-1:0]           period,
    input  logic [CHANNELS*PWM_CNT-1:0]  cmp,
    input  logic                         load,
    output logic [CHANNELS-1:0]          pwm,
    output logic                         sync,
    output logic                         pending
);
    typedef enum logic {UP, DOWN} dir_e;

    logic [PWM_CNT-1:0]          cnt_q, cnt_d, period_a_q, period_a_d, period_s_q, period_s_d;
    logic [CHANNELS*PWM_CNT-1:0] cmp_a_q, cmp_a_d, cmp_s_q, cmp_s_d;
    logic                        mode_a_q, mode_a_d, mode_s_q, mode_s_d;
    logic                        pending_q, pending_d, sync_q, sync_d;
    logic [CHANNELS-1:0]         pwm_q, pwm_d;
    dir_e                        dir_q, dir_d;
    logic                        top, bnd, take_in, take_sh;

    always_comb begin
        top = cnt_q == period_a_q;
        // Center mode with period 1 has no down leg, so the top is the boundary.
        bnd = !en || period_a_q == '0 ||
              (mode_a_q ? ((dir_q == DOWN && cnt_q == PWM_CNT'(1)) || (top && period_a_q == PWM_CNT'(1))) : top);
        take_in = bnd && load;
        take_sh = bnd && !load && pending_q;
        mode_s_d   = load ? mode : mode_s_q;
        period_s_d = load ? period : period_s_q;
        cmp_s_d    = load ? cmp : cmp_s_q;
        mode_a_d   = take_in ? mode : take_sh ? mode_s_q : mode_a_q;
        period_a_d = take_in ? period : take_sh ? period_s_q : period_a_q;
        cmp_a_d    = take_in ? cmp : take_sh ? cmp_s_q : cmp_a_q;
        pending_d  = load ? !bnd : (bnd ? 1'b0 : pending_q);
        cnt_d = cnt_q + PWM_CNT'(1);
        dir_d = UP;
        if (bnd) begin
            cnt_d = '0;
        end else if (mode_a_q && dir_q == DOWN) begin
            cnt_d = cnt_q - PWM_CNT'(1);
            dir_d = DOWN;
        end else if (mode_a_q && top) begin
            cnt_d = period_a_q - PWM_CNT'(1);
            dir_d = DOWN;
        end
        for (int i = 0; i < CHANNELS; i++)
            pwm_d[i] = en && (cmp_a_q[i*PWM_CNT +: PWM_CNT] > cnt_q);
        sync_d = en && cnt_q == '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            dir_q      <= UP;
            mode_a_q   <= 1'b0;
            period_a_q <= '1;
            cmp_a_q    <= '0;
            mode_s_q   <= 1'b0;
            period_s_q <= '1;
            cmp_s_q    <= '0;
            pending_q  <= 1'b0;
            pwm_q      <= '0;
            sync_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            mode_a_q   <= mode_a_d;
            period_a_q <= period_a_d;
            cmp_a_q    <= cmp_a_d;
            mode_s_q   <= mode_s_d;
            period_s_q <= period_s_d;
            cmp_s_q    <= cmp_s_d;
            pending_q  <= pending_d;
            pwm_q      <= pwm_d;
            sync_q     <= sync_d;
        end
    end

    assign pwm     = pwm_q;
    assign sync    = sync_q;
    assign pending = pending_q;
endmodule
